// File: rtl/name_assembler.sv
// Packs a valid/ready stream of name components into fixed-width, zero-padded name
// vectors, double-buffered so one name can drain while the next one fills.
module name_assembler #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WORD_SIZE-1:0] word_in,
    input  logic                 word_valid_in,
    input  logic                 word_last_in,
    output logic                 word_ready_out,
    output logic [WORD_SIZE-1:0] name_out [MAX_NAME_LENGTH],
    output logic [LEN_WIDTH-1:0] name_len_out,
    output logic                 name_trunc_out,
    output logic                 name_valid_out,
    input  logic                 name_ready_in
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_NAME_LENGTH);
    localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);
    localparam bit SINGLE_WORD_SLOTS = (MAX_NAME_LENGTH == 1);

    state_t               state_q;
    logic [LEN_WIDTH-1:0] count_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           occ_q;

    logic [WORD_SIZE-1:0] slot_words_q [2][MAX_NAME_LENGTH];
    logic [LEN_WIDTH-1:0] slot_len_q   [2];
    logic                 slot_trunc_q [2];

    logic                 xfer;
    logic                 drain;
    logic                 start;
    logic                 fill_xfer;
    logic                 commit;
    logic                 to_discard;
    logic [LEN_WIDTH-1:0] count_inc;
    logic [LEN_WIDTH-1:0] commit_len;
    logic                 commit_trunc;

    assign name_valid_out = (occ_q != 2'd0);
    assign drain          = name_valid_out && name_ready_in;

    // Only a new or growing name can collide with two committed slots; a drain in
    // the same cycle frees the slot being overwritten at the following edge.
    assign word_ready_out = !((state_q != DISCARD) && (occ_q == 2'd2) && !drain);

    assign xfer      = word_valid_in && word_ready_out;
    assign start     = xfer && (state_q == IDLE);
    assign fill_xfer = xfer && (state_q == FILL);
    assign commit    = xfer && word_last_in;
    assign count_inc = (count_q >= MAX_LEN) ? MAX_LEN : count_q + ONE_LEN;

    always_comb begin
        commit_len   = MAX_LEN;
        commit_trunc = 1'b0;
        to_discard   = 1'b0;
        case (state_q)
            IDLE: begin
                commit_len = ONE_LEN;
                to_discard = start && !word_last_in && SINGLE_WORD_SLOTS;
            end
            FILL: begin
                commit_len = count_inc;
                to_discard = fill_xfer && !word_last_in && (count_q == MAX_LEN - ONE_LEN);
            end
            DISCARD: begin
                commit_len   = MAX_LEN;
                commit_trunc = 1'b1;
            end
            default: begin
                commit_len   = MAX_LEN;
                commit_trunc = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q <= ONE_LEN;
                        if (to_discard) begin
                            state_q <= DISCARD;
                        end else if (!word_last_in) begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (fill_xfer) begin
                        count_q <= count_inc;
                        if (word_last_in) begin
                            state_q <= IDLE;
                        end else if (to_discard) begin
                            state_q <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (commit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (commit) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (drain) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({commit, drain})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Slot storage: the first word of a name also zero-pads the rest of its slot.
    for (genvar gs = 0; gs < 2; gs++) begin : g_slot
        for (genvar gi = 0; gi < MAX_NAME_LENGTH; gi++) begin : g_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_words_q[gs][gi] <= '0;
                end else if (wr_ptr_q == 1'(gs)) begin
                    if (start) begin
                        slot_words_q[gs][gi] <= (gi == 0) ? word_in : '0;
                    end else if (fill_xfer && (count_q == LEN_WIDTH'(gi))) begin
                        slot_words_q[gs][gi] <= word_in;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_len_q[gs]   <= '0;
                slot_trunc_q[gs] <= 1'b0;
            end else if (commit && (wr_ptr_q == 1'(gs))) begin
                slot_len_q[gs]   <= commit_len;
                slot_trunc_q[gs] <= commit_trunc;
            end
        end
    end

    for (genvar gi = 0; gi < MAX_NAME_LENGTH; gi++) begin : g_out
        assign name_out[gi] = slot_words_q[rd_ptr_q][gi];
    end

    assign name_len_out   = slot_len_q[rd_ptr_q];
    assign name_trunc_out = slot_trunc_q[rd_ptr_q];

endmodule

// File: tb/tb_name_assembler.sv
// Directed bench for name_assembler: single/multi-word names, backpressure,
// truncation, back-to-back throughput and asynchronous reset mid-name.
module tb_name_assembler;

    localparam int WS  = 32;
    localparam int MNL = 8;
    localparam int LW  = 4;

    logic          clk;
    logic          rst_n;
    logic [WS-1:0] word_in;
    logic          word_valid_in;
    logic          word_last_in;
    logic          word_ready_out;
    logic [WS-1:0] name_out [MNL];
    logic [LW-1:0] name_len_out;
    logic          name_trunc_out;
    logic          name_valid_out;
    logic          name_ready_in;

    int tests;
    int fails;

    name_assembler #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(MNL), .LEN_WIDTH(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .word_in        (word_in),
        .word_valid_in  (word_valid_in),
        .word_last_in   (word_last_in),
        .word_ready_out (word_ready_out),
        .name_out       (name_out),
        .name_len_out   (name_len_out),
        .name_trunc_out (name_trunc_out),
        .name_valid_out (name_valid_out),
        .name_ready_in  (name_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic send_word(input logic [WS-1:0] w, input logic last);
        bit done;
        done          = 0;
        word_in       = w;
        word_valid_in = 1'b1;
        word_last_in  = last;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            done = (word_ready_out === 1'b1);
            @(posedge clk);
            #1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL send_word timeout: word=%h never accepted", w);
        end
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (name_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b want 0", name_valid_out);
        end
        tests++;
        if (word_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", word_ready_out);
        end
        tests++;
        if (name_len_out !== 4'd0 || name_trunc_out !== 1'b0 || name_out[0] !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: len=%0d trunc=%b w0=%h want 0/0/0",
                     name_len_out, name_trunc_out, name_out[0]);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        name_ready_in = 1'b1;
        send_word(32'hA, 1'b1);
        tests++;
        if (name_valid_out !== 1'b1 || name_out[0] !== 32'hA || name_len_out !== 4'd1
            || name_trunc_out !== 1'b0) begin
            fails++;
            $display("FAIL single: valid=%b w0=%h len=%0d trunc=%b want 1/a/1/0",
                     name_valid_out, name_out[0], name_len_out, name_trunc_out);
        end
        for (int i = 1; i < MNL; i++) begin
            tests++;
            if (name_out[i] !== 32'h0) begin
                fails++;
                $display("FAIL single_pad[%0d]: got %h want 0", i, name_out[i]);
            end
        end
        tick();
        tests++;
        if (name_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL single_drained: valid=%b want 0", name_valid_out);
        end
        $display("[TB] single-word name 0xA");
    endtask

    task automatic test_three();
        logic [WS-1:0] exp_w;
        name_ready_in = 1'b1;
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        tests++;
        if (name_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL three_early_valid: got %b want 0", name_valid_out);
        end
        send_word(32'h3, 1'b1);
        tests++;
        if (name_valid_out !== 1'b1 || name_len_out !== 4'd3 || name_trunc_out !== 1'b0) begin
            fails++;
            $display("FAIL three_meta: valid=%b len=%0d trunc=%b want 1/3/0",
                     name_valid_out, name_len_out, name_trunc_out);
        end
        for (int i = 0; i < MNL; i++) begin
            exp_w = (i < 3) ? WS'(i + 1) : '0;
            tests++;
            if (name_out[i] !== exp_w) begin
                fails++;
                $display("FAIL three_word[%0d]: got %h want %h", i, name_out[i], exp_w);
            end
        end
        tick();
        $display("[TB] three-word name 1,2,3");
    endtask

    task automatic test_backpressure();
        name_ready_in = 1'b0;
        send_word(32'h11, 1'b0);
        send_word(32'h12, 1'b1);
        send_word(32'h21, 1'b0);
        send_word(32'h22, 1'b1);
        word_in       = 32'h31;
        word_valid_in = 1'b1;
        word_last_in  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (word_ready_out !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall[%0d]: ready=%b want 0", c, word_ready_out);
            end
            tests++;
            if (name_valid_out !== 1'b1 || name_out[0] !== 32'h11 || name_out[1] !== 32'h12
                || name_len_out !== 4'd2) begin
                fails++;
                $display("FAIL bp_stable[%0d]: valid=%b w0=%h w1=%h len=%0d want 1/11/12/2",
                         c, name_valid_out, name_out[0], name_out[1], name_len_out);
            end
            tick();
        end
        name_ready_in = 1'b1;
        #1;
        tests++;
        if (word_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: ready=%b want 1", word_ready_out);
        end
        tick();
        tests++;
        if (name_valid_out !== 1'b1 || name_out[0] !== 32'h21 || name_out[1] !== 32'h22) begin
            fails++;
            $display("FAIL bp_second: valid=%b w0=%h w1=%h want 1/21/22",
                     name_valid_out, name_out[0], name_out[1]);
        end
        word_in      = 32'h32;
        word_last_in = 1'b1;
        tick();
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
        tests++;
        if (name_valid_out !== 1'b1 || name_out[0] !== 32'h31 || name_out[1] !== 32'h32
            || name_out[2] !== 32'h0 || name_len_out !== 4'd2) begin
            fails++;
            $display("FAIL bp_third: valid=%b w0=%h w1=%h w2=%h len=%0d want 1/31/32/0/2",
                     name_valid_out, name_out[0], name_out[1], name_out[2], name_len_out);
        end
        tick();
        tests++;
        if (name_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: valid=%b want 0", name_valid_out);
        end
        $display("[TB] backpressure with three 2-word names");
    endtask

    task automatic test_trunc();
        name_ready_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            word_in       = WS'(i);
            word_valid_in = 1'b1;
            word_last_in  = (i == 10);
            #1;
            if (i >= 9) begin
                tests++;
                if (word_ready_out !== 1'b1) begin
                    fails++;
                    $display("FAIL trunc_accept[%0d]: ready=%b want 1", i, word_ready_out);
                end
            end
            tick();
        end
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
        tests++;
        if (name_valid_out !== 1'b1 || name_len_out !== 4'd8 || name_trunc_out !== 1'b1) begin
            fails++;
            $display("FAIL trunc_meta: valid=%b len=%0d trunc=%b want 1/8/1",
                     name_valid_out, name_len_out, name_trunc_out);
        end
        for (int i = 0; i < MNL; i++) begin
            tests++;
            if (name_out[i] !== WS'(i + 1)) begin
                fails++;
                $display("FAIL trunc_word[%0d]: got %h want %h", i, name_out[i], WS'(i + 1));
            end
        end
        tick();
        for (int i = 0; i < MNL; i++) begin
            send_word(WS'(32'h101 + i), (i == MNL - 1));
        end
        tests++;
        if (name_valid_out !== 1'b1 || name_len_out !== 4'd8 || name_trunc_out !== 1'b0
            || name_out[0] !== 32'h101 || name_out[7] !== 32'h108) begin
            fails++;
            $display("FAIL exact8: valid=%b len=%0d trunc=%b w0=%h w7=%h want 1/8/0/101/108",
                     name_valid_out, name_len_out, name_trunc_out, name_out[0], name_out[7]);
        end
        tick();
        $display("[TB] truncation of 10-word name and exact 8-word name");
    endtask

    task automatic test_back_to_back();
        name_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            word_in       = WS'(32'h50 + i);
            word_valid_in = 1'b1;
            word_last_in  = 1'b1;
            #1;
            tests++;
            if (word_ready_out !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, word_ready_out);
            end
            tick();
            tests++;
            if (name_valid_out !== 1'b1 || name_out[0] !== WS'(32'h50 + i)
                || name_len_out !== 4'd1) begin
                fails++;
                $display("FAIL b2b_name[%0d]: valid=%b w0=%h len=%0d want 1/%h/1",
                         i, name_valid_out, name_out[0], name_len_out, WS'(32'h50 + i));
            end
        end
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
        tick();
        tests++;
        if (name_valid_out !== 1'b0) begin
            fails++;
            $display("FAIL b2b_empty: valid=%b want 0", name_valid_out);
        end
        $display("[TB] back-to-back single-word names");
    endtask

    task automatic test_reset_mid();
        name_ready_in = 1'b1;
        send_word(32'h61, 1'b0);
        send_word(32'h62, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (name_valid_out !== 1'b0 || word_ready_out !== 1'b1) begin
                fails++;
                $display("FAIL rst_mid_idle[%0d]: valid=%b ready=%b want 0/1",
                         c, name_valid_out, word_ready_out);
            end
        end
        send_word(32'h71, 1'b1);
        tests++;
        if (name_valid_out !== 1'b1 || name_out[0] !== 32'h71 || name_out[1] !== 32'h0
            || name_len_out !== 4'd1 || name_trunc_out !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_next: valid=%b w0=%h w1=%h len=%0d trunc=%b want 1/71/0/1/0",
                     name_valid_out, name_out[0], name_out[1], name_len_out, name_trunc_out);
        end
        tick();
        $display("[TB] async reset mid-name");
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        word_in       = '0;
        word_valid_in = 1'b0;
        word_last_in  = 1'b0;
        name_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        test_reset();
        test_single();
        test_three();
        test_backpressure();
        test_trunc();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
